msfp8_vec_unpack: RTL and testbench

Streaming unpacker that sits directly downstream of the MVU's MSFP8 vector memory read port and upstream of the FP16 datapath. It accepts packed words of LANES msfp8 values (1 sign, 5 exponent, 2 mantissa bits, bias 15) over a valid/ready handshake and emits one FP16 value per cycle, lane 0 first, with its own valid/ready handshake. It also raises a sticky flag when it sees Inf or NaN.

---
 rtl/msfp8_vec_unpack_pkg.sv | 30 +++
 rtl/msfp8_vec_unpack_if.sv | 29 ++
 rtl/msfp8_vec_unpack_lane_cvt.sv | 33 +++
 rtl/msfp8_vec_unpack.sv | 126 ++++++++++++
 tb/tb_msfp8_vec_unpack.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/msfp8_vec_unpack_pkg.sv
// msfp8_pkg: shared field widths, element types and FSM encoding for the
// msfp8 -> FP16 vector unpacker.
package msfp8_pkg;

  localparam int MSFP8_EXP_W = 5;
  localparam int MSFP8_MAN_W = 2;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MAN_W  = 10;

  // Exponent code reserved for Inf/NaN in both formats
  localparam logic [MSFP8_EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef struct packed {
    logic                   sign;
    logic [MSFP8_EXP_W-1:0] exp;
    logic [MSFP8_MAN_W-1:0] man;
  } msfp8_t;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/msfp8_vec_unpack_if.sv
// Input word stream and output element stream of the msfp8 unpacker.
// The block itself uses the slave modport; the producer/consumer side
// (memory read port + FP16 datapath, or a bench) uses master.
interface msfp8_vec_unpack_if #(
  parameter int LANES = 4
);
  localparam int LANE_W = $clog2(LANES);

  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic [LANE_W-1:0]    out_lane;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last
  );

endinterface

// File: rtl/msfp8_vec_unpack_lane_cvt.sv
// msfp8_lane_cvt: combinational single-element msfp8 -> FP16 converter.
// Optional build macro: MSFP8_UNPACK_FTZ_EN flushes subnormal inputs to
// signed zero instead of converting them exactly.
module msfp8_lane_cvt
  import msfp8_pkg::*;
(
  input  msfp8_t din,
  output fp16_t  dout,
  output logic   is_special
);

  // Both formats use bias 15, so the exponent passes straight through and
  // the 2-bit mantissa becomes the top of the 10-bit FP16 mantissa.
  always_comb begin
    dout       = '0;
    dout.sign  = din.sign;
    is_special = (din.exp == EXP_ALL_ONES);
    if (din.exp == '0) begin
      if (din.man != '0) begin
`ifdef MSFP8_UNPACK_FTZ_EN
        dout.man = '0;
`else
        dout.man = {din.man, {(FP16_MAN_W-MSFP8_MAN_W){1'b0}}};
`endif
      end
    end else begin
      // Normal numbers and Inf/NaN alike; NaN payload is preserved
      dout.exp = din.exp;
      dout.man = {din.man, {(FP16_MAN_W-MSFP8_MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/msfp8_vec_unpack.sv
// msfp8_vec_unpack: takes packed words of LANES msfp8 values and streams
// them out one FP16 element per cycle, lane 0 first. Raises a sticky flag
// when an emitted element is Inf/NaN.
// Optional build macro: MSFP8_UNPACK_FTZ_EN (see msfp8_lane_cvt).
module msfp8_vec_unpack
  import msfp8_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  msfp8_vec_unpack_if.slave      bus,
  input  logic                   clr_special,
  output logic                   special_seen
);

  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  unpack_state_t        state_reg, state_next;
  logic [LANE_W-1:0]    lane_reg, lane_next;
  logic [8*LANES-1:0]   held_data_reg, held_data_next;
  logic                 held_last_reg, held_last_next;
  logic                 special_reg, special_next;

  logic [7:0]           lane_bytes [LANES];
  msfp8_t               cur_elem;
  fp16_t                cur_fp16;
  logic                 cur_special;
  logic                 busy;
  logic                 last_lane;
  logic                 out_fire;
  logic                 in_fire;

  // Split the holding register into per-lane bytes for the lane mux
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_bytes
      assign lane_bytes[gi] = held_data_reg[8*gi +: 8];
    end
  endgenerate

  assign cur_elem = msfp8_t'(lane_bytes[lane_reg]);

  msfp8_lane_cvt u_cvt (
    .din        (cur_elem),
    .dout       (cur_fp16),
    .is_special (cur_special)
  );

  assign busy      = (state_reg == ST_BUSY);
  assign last_lane = (lane_reg == LAST_LANE);
  assign out_fire  = busy && bus.out_ready;
  assign in_fire   = bus.in_valid && bus.in_ready;

  // Accept a new word while empty, or in the same cycle the final lane
  // leaves, so consecutive words stream with no bubble.
  assign bus.in_ready  = !busy || (last_lane && bus.out_ready);
  assign bus.out_valid = busy;
  assign bus.out_data  = cur_fp16;
  assign bus.out_lane  = lane_reg;
  assign bus.out_last  = held_last_reg && last_lane;
  assign special_seen  = special_reg;

  // Next-state logic: lane walk, word capture and sticky special flag
  always_comb begin
    state_next     = state_reg;
    lane_next      = lane_reg;
    held_data_next = held_data_reg;
    held_last_next = held_last_reg;
    special_next   = special_reg;

    // Set has priority over a simultaneous clear
    if (out_fire && cur_special) begin
      special_next = 1'b1;
    end else if (clr_special) begin
      special_next = 1'b0;
    end

    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next     = ST_BUSY;
          lane_next      = '0;
          held_data_next = bus.in_data;
          held_last_next = bus.in_last;
        end
      end
      ST_BUSY: begin
        if (out_fire) begin
          if (!last_lane) begin
            lane_next = lane_reg + 1'b1;
          end else if (in_fire) begin
            lane_next      = '0;
            held_data_next = bus.in_data;
            held_last_next = bus.in_last;
          end else begin
            state_next = ST_EMPTY;
            lane_next  = '0;
          end
        end
      end
      default: begin
        state_next = ST_EMPTY;
        lane_next  = '0;
      end
    endcase
  end

  // State and holding registers; reset discards any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      lane_reg      <= '0;
      held_data_reg <= '0;
      held_last_reg <= 1'b0;
      special_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lane_reg      <= lane_next;
      held_data_reg <= held_data_next;
      held_last_reg <= held_last_next;
      special_reg   <= special_next;
    end
  end

endmodule

// File: tb/tb_msfp8_vec_unpack.sv
// Self-checking bench for msfp8_vec_unpack (LANES=4). Works for both the
// default build and the MSFP8_UNPACK_FTZ_EN build.
module tb_msfp8_vec_unpack;

  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_special = 1'b0;
  logic special_seen;

  msfp8_vec_unpack_if #(.LANES(LANES)) bus ();

  msfp8_vec_unpack #(.LANES(LANES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .clr_special  (clr_special),
    .special_seen (special_seen)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes of the word still to be emitted, in order
  logic [7:0] byte_q[$];
  logic       m_last    = 1'b0;
  logic       m_special = 1'b0;
  logic       accepted  = 1'b0;

  // msfp8 and FP16 share sign position, 5-bit exponent and bias, so an
  // msfp8 code scaled by 256 is the FP16 code of the same value.
  function automatic logic [15:0] ref_cvt(input logic [7:0] a);
    int e;
    e = (a >> 2) & 31;
`ifdef MSFP8_UNPACK_FTZ_EN
    if (e == 0) return (a >= 8'h80) ? 16'h8000 : 16'h0000;
`endif
    return 16'(a * 256);
  endfunction

  function automatic logic ref_special(input logic [7:0] a);
    return ((a >> 2) & 31) == 31;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    case ($urandom_range(0, 3))
      0: b[6:2] = 5'h1f;
      1: b[6:2] = 5'h00;
      default: ;
    endcase
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check every output
  // against the model, advance the model across the rising edge.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic l,
                       input logic ordy, input logic clr);
    logic m_ready;
    int   rem;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    clr_special   = clr;
    #1;
    rem     = byte_q.size();
    m_ready = (rem == 0) || (rem == 1 && ordy);
    chk("out_valid", 32'(bus.out_valid), 32'(rem > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
    chk("special_seen", 32'(special_seen), 32'(m_special));
    if (rem > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(ref_cvt(byte_q[0])));
      chk("out_lane", 32'(bus.out_lane), 32'(LANES - rem));
      chk("out_last", 32'(bus.out_last), 32'(rem == 1 && m_last));
    end
    accepted = iv && m_ready;
    if (rem > 0 && ordy && ref_special(byte_q[0])) m_special = 1'b1;
    else if (clr) m_special = 1'b0;
    if (rem > 0 && ordy) void'(byte_q.pop_front());
    if (accepted) begin
      for (int i = 0; i < LANES; i++) byte_q.push_back(d[8*i +: 8]);
      m_last = l;
    end
    @(negedge clk);
  endtask

  logic [15:0] exp_t1 [4];
  logic [31:0] wa, wb, wd;
  logic        have, wl;

  initial begin
`ifdef MSFP8_UNPACK_FTZ_EN
    exp_t1[0] = 16'h0000;
`else
    exp_t1[0] = 16'h0100;
`endif
    exp_t1[1] = 16'h3C00;
    exp_t1[2] = 16'hBD00;
    exp_t1[3] = 16'h7C00;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_lane", 32'(bus.out_lane), 32'd0);
    chk("rst_special", 32'(special_seen), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact conversion of 7CBD3C01, last word of a vector
    cycle(1'b1, 32'h7CBD3C01, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_data", 32'(bus.out_data), 32'(exp_t1[k]));
      chk("t1_lane", 32'(bus.out_lane), 32'(k));
      chk("t1_last", 32'(bus.out_last), 32'(k == 3));
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("t1_special", 32'(special_seen), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t1_clr", 32'(special_seen), 32'd0);

    // Signed zero and NaN; clear colliding with a NaN handshake
    cycle(1'b1, 32'h0000_7D80, 1'b1, 1'b1, 1'b0);
    chk("t2_negzero", 32'(bus.out_data), 32'h8000);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_nan", 32'(bus.out_data), 32'h7D00);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t2_set_wins", 32'(special_seen), 32'd1);
    chk("t2_zero", 32'(bus.out_data), 32'h0000);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t2_clr", 32'(special_seen), 32'd0);

    // Back-pressure on lane 2
    cycle(1'b1, 32'h7CBD3C01, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("bp_hold", 32'(bus.out_data), 32'hBD00);
      chk("bp_lane", 32'(bus.out_lane), 32'd2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_release", 32'(bus.out_data), 32'h7C00);
    chk("bp_release_lane", 32'(bus.out_lane), 32'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Back-to-back words, no bubble
    wa = $urandom; wb = $urandom;
    cycle(1'b1, wa, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_ready", 32'(bus.in_ready), 32'((k % 4) == 3));
      cycle(k < 4, wb, 1'b1, 1'b1, 1'b0);
    end
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Reset while lane 1 is presented
    cycle(1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_lane", 32'(bus.out_lane), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    byte_q.delete();
    m_last = 1'b0;
    m_special = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h3C7C0004, 1'b1, 1'b1, 1'b0);
    chk("post_rst_lane", 32'(bus.out_lane), 32'd0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model
    have = 1'b0; wd = '0; wl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        wd = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
        wl = 1'($urandom_range(0, 1));
      end
      cycle(have, wd, wl, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      if (accepted) have = 1'b0;
    end
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
